fmap_stream_tx: RTL and testbench
=================================

FMAP_STREAM_TX -- requirements
Module: fmap_stream_tx

Interface
REQ-001 The block SHALL have parameter IMG_W, default 28, meaning feature-map width in pixels.
REQ-002 The block SHALL have parameter IMG_H, default 28, meaning feature-map height in pixels.
REQ-003 The block SHALL have parameter CH, default 8, meaning channels per pixel; byte lanes fixed at 8 bits.
REQ-004 The block SHALL have parameter FLUSH_ROWS, default 1, meaning zero rows appended after the frame to drain downstream line buffers.
REQ-005 The block SHALL have parameter BASE_ADDR, default 0, meaning memory word address of pixel (0,0).
REQ-006 The block SHALL have port clk, input, 1, meaning clock; all logic on rising edge.
REQ-007 The block SHALL have port rst_n, input, 1, meaning reset, asynchronous, active-low.
REQ-008 The block SHALL have port start, input, 1, meaning frame-start request; sampled only in IDLE.
REQ-009 The block SHALL have port abort, input, 1, meaning synchronous cancel of the current frame.
REQ-010 The block SHALL have port stall, input, 1, meaning downstream hold request.
REQ-011 The block SHALL have port mem_rd_en, output, 1, meaning memory read strobe.
REQ-012 The block SHALL have port mem_addr, output, AW = clog2(BASE_ADDR+IMG_W*IMG_H) (min 1), meaning read word address.
REQ-013 The block SHALL have port mem_rdata, input, 8*CH, meaning read data, valid exactly 1 cycle after mem_rd_en.
REQ-014 The block SHALL have ports out_data0..out_data7, output, 8 each, meaning per-channel pixel bytes.
REQ-015 The block SHALL have port out_valid, output, 1, meaning out_data* holds a pixel this cycle.
REQ-016 The block SHALL have port out_last, output, 1, meaning final valid pixel of frame including flush.
REQ-017 The block SHALL have ports busy and done, output, 1 each, meaning not-IDLE and 1-cycle frame-complete pulse.

Function
REQ-018 The FSM SHALL have states IDLE, READ, FLUSH, DONE; IDLE->READ on start; READ->FLUSH after read of pixel IMG_W*IMG_H-1 issues (READ->DONE if FLUSH_ROWS=0); FLUSH->DONE after FLUSH_ROWS*IMG_W zero pixels issue; DONE->IDLE unconditionally after 1 cycle.
REQ-019 In READ, each cycle with stall=0 SHALL assert mem_rd_en with mem_addr = BASE_ADDR + row*IMG_W + col, then advance col; col wraps at IMG_W-1 to 0 with row+1.
REQ-020 A cycle with stall=1 SHALL issue no read or flush pixel and SHALL hold counters; a pixel issued before stall rose still emits the following cycle (1-cycle stall lag).
REQ-021 out_valid SHALL be a register equal to the previous cycle's issue strobe (read or flush), giving start-to-first-out_valid latency of 2 cycles.
REQ-022 For read pixels out_data_k SHALL equal mem_rdata[8k+7:8k]; for flush pixels all out_data_k SHALL be 0; when out_valid=0 out_data* SHALL hold last value.
REQ-023 out_last SHALL assert with out_valid for the final issued pixel only; done SHALL pulse in DONE state, the cycle after out_last.
REQ-024 start while busy SHALL be ignored; start and abort in same IDLE cycle SHALL leave block in IDLE.
REQ-025 abort in any non-IDLE state SHALL return to IDLE next cycle, clear counters, suppress the in-flight out_valid and out_last, and not pulse done.
REQ-026 A frame SHALL emit exactly (IMG_H+FLUSH_ROWS)*IMG_W valid pixels in raster order regardless of stall pattern.

Reset
REQ-027 On rst_n low, state SHALL be IDLE, counters 0, and mem_rd_en, mem_addr, out_data*, out_valid, out_last, busy, done SHALL be 0 immediately; reset mid-frame discards the frame.

Structure
REQ-028 Shared package SHALL hold the FSM state encoding, byte-lane width 8, and the default IMG_W/IMG_H constants shared with the convolution layers.
REQ-029 One sub-module, raster_counter (col/row counter with enable, clear and wrap flags), SHALL be instantiated for both READ and FLUSH phases.

Verification
REQ-030 IMG_W=4, IMG_H=3, FLUSH_ROWS=1, mem word n = {8{n[7:0]}}: start pulse -> out_valid on cycles 2..17, out_data0 = 0..11 then 0,0,0,0, out_last at 17, done at 18.
REQ-031 Same setup, stall high cycles 4-6 -> no mem_rd_en in 4-6, out_valid gap 5-7, 16 pixels total, order unchanged.
REQ-032 abort at cycle 6 -> busy low at 7, no out_valid from 7, done never pulses; new start at 10 restarts at address 0.
REQ-033 start held during busy -> exactly one frame of 16 pixels and one done.
REQ-034 rst_n low at cycle 8 mid-READ -> all outputs 0 same cycle; after release, start replays full frame from address BASE_ADDR.
REQ-035 FLUSH_ROWS=0, BASE_ADDR=16 -> 12 pixels, addresses 16..27, out_last on 12th pixel, done next cycle.

Source files
------------

// File: rtl/fmap_stream_tx_pkg.sv
// fmap_stream_tx_pkg: state encoding, byte-lane width and the default feature-map size
// shared with the convolution layers.
package fmap_stream_tx_pkg;
  localparam int LANE_W = 8;
  localparam int DEF_IMG_W = 28;
  localparam int DEF_IMG_H = 28;
  typedef enum logic [1:0] {IDLE, READ, FLUSH, DONE} state_t;
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/fmap_stream_tx_raster_counter.sv
// raster_counter: col/row raster counter with enable and clear; wrap_o flags the last
// pixel of a phase whose final row index is row_lim_i.
module raster_counter #(
  parameter int W  = 4,
  parameter int CW = 2,
  parameter int RW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en_i,
  input  logic          clr_i,
  input  logic [RW-1:0] row_lim_i,
  output logic [CW-1:0] col_o,
  output logic [RW-1:0] row_o,
  output logic          wrap_o
);
  logic [CW-1:0] col_q;
  logic [RW-1:0] row_q;
  logic          col_wrap;
  assign col_wrap = col_q == CW'(W - 1);
  assign wrap_o   = col_wrap && row_q == row_lim_i;
  assign col_o    = col_q;
  assign row_o    = row_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else if (clr_i) begin
      col_q <= '0;
      row_q <= '0;
    end else if (en_i) begin
      col_q <= col_wrap ? '0 : col_q + 1'b1;
      row_q <= col_wrap ? row_q + 1'b1 : row_q;
    end
endmodule

// File: rtl/fmap_stream_tx.sv
// fmap_stream_tx: streams a feature map from memory in raster order, then appends
// zero flush rows; one pixel per unstalled cycle with a one-cycle memory latency.
module fmap_stream_tx
  import fmap_stream_tx_pkg::*;
#(
  parameter int IMG_W      = DEF_IMG_W,
  parameter int IMG_H      = DEF_IMG_H,
  parameter int CH         = 8,
  parameter int FLUSH_ROWS = 1,
  parameter int BASE_ADDR  = 0,
  localparam int AW = clog2_min1(BASE_ADDR + IMG_W * IMG_H)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 stall,
  output logic                 mem_rd_en,
  output logic [AW-1:0]        mem_addr,
  input  logic [LANE_W*CH-1:0] mem_rdata,
  output logic [LANE_W-1:0]    out_data0,
  output logic [LANE_W-1:0]    out_data1,
  output logic [LANE_W-1:0]    out_data2,
  output logic [LANE_W-1:0]    out_data3,
  output logic [LANE_W-1:0]    out_data4,
  output logic [LANE_W-1:0]    out_data5,
  output logic [LANE_W-1:0]    out_data6,
  output logic [LANE_W-1:0]    out_data7,
  output logic                 out_valid,
  output logic                 out_last,
  output logic                 busy,
  output logic                 done
);
  localparam int CW = clog2_min1(IMG_W);
  localparam int RH = (IMG_H > FLUSH_ROWS) ? IMG_H : FLUSH_ROWS;
  localparam int RW = clog2_min1(RH);
  state_t                   state_q, state_d;
  logic                     out_valid_q, out_last_q, flush_q, done_q;
  logic [7:0][LANE_W-1:0]   hold_q, lane, data;
  logic                     active, issue, phase_end, last_px, cnt_clr;
  logic [CW-1:0]            col;
  logic [RW-1:0]            row, row_lim;
  logic [AW-1:0]            addr;
  assign active    = state_q == READ || state_q == FLUSH;
  assign issue     = active && !stall && !abort;
  assign last_px   = issue && phase_end && (state_q == FLUSH || FLUSH_ROWS == 0);
  assign cnt_clr   = abort || !active || (issue && phase_end);
  assign row_lim   = RW'(state_q == FLUSH ? FLUSH_ROWS - 1 : IMG_H - 1);
  assign addr      = AW'(BASE_ADDR) + AW'(row) * AW'(IMG_W) + AW'(col);
  assign mem_rd_en = issue && state_q == READ;
  assign mem_addr  = mem_rd_en ? addr : '0;
  assign busy      = state_q != IDLE;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign done      = done_q;
  raster_counter #(.W(IMG_W), .CW(CW), .RW(RW)) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .en_i     (issue),
    .clr_i    (cnt_clr),
    .row_lim_i(row_lim),
    .col_o    (col),
    .row_o    (row),
    .wrap_o   (phase_end)
  );
  // Memory data arrives in the out_valid cycle, so lanes pass through combinationally.
  for (genvar k = 0; k < 8; k++) begin : g_lane
    if (k < CH) begin : g_on
      assign lane[k] = flush_q ? '0 : mem_rdata[LANE_W*k +: LANE_W];
    end else begin : g_off
      assign lane[k] = '0;
    end
  end
  assign data      = out_valid_q ? lane : hold_q;
  assign out_data0 = data[0];
  assign out_data1 = data[1];
  assign out_data2 = data[2];
  assign out_data3 = data[3];
  assign out_data4 = data[4];
  assign out_data5 = data[5];
  assign out_data6 = data[6];
  assign out_data7 = data[7];
  always_comb
    state_d = (state_q == IDLE) ? (start ? READ : IDLE) :
              (state_q == DONE) ? IDLE :
              (issue && phase_end) ? ((state_q == FLUSH || FLUSH_ROWS == 0) ? DONE : FLUSH) :
              state_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      flush_q     <= 1'b0;
      done_q      <= 1'b0;
      hold_q      <= '0;
    end else begin
      state_q     <= abort ? IDLE : state_d;
      out_valid_q <= issue;
      out_last_q  <= last_px;
      flush_q     <= issue && state_q == FLUSH;
      done_q      <= state_q == DONE && !abort;
      hold_q      <= data;
    end
endmodule

// File: tb/tb_fmap_stream_tx.sv
// tb_fmap_stream_tx: directed frames on a 4x3 map (flush and no-flush variants) with
// address/pixel scoreboards and per-cycle timing checks.
module tb_fmap_stream_tx;
  logic        clk = 0, rst_n = 0, start_a = 0, start_b = 0, abort = 0, stall = 0;
  logic        a_rd, a_valid, a_last, a_busy, a_done;
  logic        b_rd, b_valid, b_last, b_busy, b_done;
  logic [3:0]  a_addr;
  logic [4:0]  b_addr;
  logic [63:0] a_rdata = '0, b_rdata = '0;
  logic [7:0]  a_d [8];
  logic [7:0]  b_d [8];
  logic [7:0]  a_ad_q [$];
  logic [7:0]  b_ad_q [$];
  logic [8:0]  a_px_q [$];
  logic [8:0]  b_px_q [$];
  logic [8:0]  a_e, b_e;
  logic [7:0]  a_hold = 0, b_hold = 0;
  int          n_cmp = 0, n_bad = 0, cnt_v, cnt_d;

  fmap_stream_tx #(.IMG_W(4), .IMG_H(3), .CH(8), .FLUSH_ROWS(1), .BASE_ADDR(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort), .stall(stall),
    .mem_rd_en(a_rd), .mem_addr(a_addr), .mem_rdata(a_rdata),
    .out_data0(a_d[0]), .out_data1(a_d[1]), .out_data2(a_d[2]), .out_data3(a_d[3]),
    .out_data4(a_d[4]), .out_data5(a_d[5]), .out_data6(a_d[6]), .out_data7(a_d[7]),
    .out_valid(a_valid), .out_last(a_last), .busy(a_busy), .done(a_done));

  fmap_stream_tx #(.IMG_W(4), .IMG_H(3), .CH(8), .FLUSH_ROWS(0), .BASE_ADDR(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort), .stall(stall),
    .mem_rd_en(b_rd), .mem_addr(b_addr), .mem_rdata(b_rdata),
    .out_data0(b_d[0]), .out_data1(b_d[1]), .out_data2(b_d[2]), .out_data3(b_d[3]),
    .out_data4(b_d[4]), .out_data5(b_d[5]), .out_data6(b_d[6]), .out_data7(b_d[7]),
    .out_valid(b_valid), .out_last(b_last), .busy(b_busy), .done(b_done));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (a_rd) a_rdata <= {8{8'(a_addr)}};
    if (b_rd) b_rdata <= {8{8'(b_addr)}};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push_a();
    for (int i = 0; i < 12; i++) a_ad_q.push_back(8'(i));
    for (int i = 0; i < 16; i++) a_px_q.push_back({i == 15, (i < 12) ? 8'(i) : 8'd0});
  endtask

  task automatic push_b();
    for (int i = 16; i < 28; i++) begin
      b_ad_q.push_back(8'(i));
      b_px_q.push_back({i == 27, 8'(i)});
    end
  endtask

  task automatic clear_a();
    a_ad_q.delete();
    a_px_q.delete();
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      a_hold = 0;
      b_hold = 0;
    end else begin
      if (a_rd) begin
        chk("a_addr_avail", a_ad_q.size() > 0, 1);
        if (a_ad_q.size() > 0) chk("a_addr", a_addr, a_ad_q.pop_front());
      end
      if (a_valid) begin
        chk("a_px_avail", a_px_q.size() > 0, 1);
        if (a_px_q.size() > 0) begin
          a_e = a_px_q.pop_front();
          chk("a_data0", a_d[0], a_e[7:0]);
          chk("a_data7", a_d[7], a_e[7:0]);
          chk("a_last", a_last, a_e[8]);
          a_hold = a_e[7:0];
        end
      end else chk("a_hold", a_d[0], a_hold);
      if (b_rd) begin
        chk("b_addr_avail", b_ad_q.size() > 0, 1);
        if (b_ad_q.size() > 0) chk("b_addr", b_addr, b_ad_q.pop_front());
      end
      if (b_valid) begin
        chk("b_px_avail", b_px_q.size() > 0, 1);
        if (b_px_q.size() > 0) begin
          b_e = b_px_q.pop_front();
          chk("b_data0", b_d[0], b_e[7:0]);
          chk("b_data3", b_d[3], b_e[7:0]);
          chk("b_last", b_last, b_e[8]);
          b_hold = b_e[7:0];
        end
      end else chk("b_hold", b_d[0], b_hold);
    end
  end

  initial begin
    #3;
    chk("rst_rd", a_rd, 0);
    chk("rst_addr", a_addr, 0);
    chk("rst_valid", a_valid, 0);
    chk("rst_last", a_last, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_done", a_done, 0);
    chk("rst_data", a_d[0], 0);
    @(posedge clk);
    #1 rst_n = 1;
    next_cycle();
    // plain frame
    for (int c = 0; c < 20; c++) begin
      start_a = c == 0;
      if (c == 0) push_a();
      @(negedge clk);
      chk("A_rd", a_rd, c >= 1 && c <= 12);
      chk("A_valid", a_valid, c >= 2 && c <= 17);
      chk("A_last", a_last, c == 17);
      chk("A_done", a_done, c == 18);
      chk("A_busy", a_busy, c >= 1 && c <= 17);
      next_cycle();
    end
    chk("A_q_empty", a_px_q.size() + a_ad_q.size(), 0);
    // stall cycles 4-6
    for (int c = 0; c < 23; c++) begin
      start_a = c == 0;
      stall = c >= 4 && c <= 6;
      if (c == 0) push_a();
      @(negedge clk);
      chk("B_rd", a_rd, c >= 1 && c <= 15 && !(c >= 4 && c <= 6));
      chk("B_valid", a_valid, (c >= 2 && c <= 4) || (c >= 8 && c <= 20));
      chk("B_last", a_last, c == 20);
      chk("B_done", a_done, c == 21);
      next_cycle();
    end
    stall = 0;
    chk("B_q_empty", a_px_q.size() + a_ad_q.size(), 0);
    // abort at 6, restart at 10
    for (int c = 0; c < 30; c++) begin
      start_a = c == 0 || c == 10;
      abort = c == 6;
      if (c == 0) push_a();
      if (c == 7) clear_a();
      if (c == 10) push_a();
      @(negedge clk);
      if (c == 11) chk("C_restart_addr", {a_rd, a_addr}, {1'b1, 4'd0});
      chk("C_valid", a_valid, (c >= 2 && c <= 6) || (c >= 12 && c <= 27));
      chk("C_busy", a_busy, (c >= 1 && c <= 6) || (c >= 11 && c <= 27));
      chk("C_done", a_done, c == 28);
      next_cycle();
    end
    abort = 0;
    chk("C_q_empty", a_px_q.size() + a_ad_q.size(), 0);
    // start held while busy
    cnt_v = 0;
    cnt_d = 0;
    for (int c = 0; c < 26; c++) begin
      start_a = c <= 17;
      if (c == 0) push_a();
      @(negedge clk);
      cnt_v += int'(a_valid);
      cnt_d += int'(a_done);
      next_cycle();
    end
    chk("D_pixels", cnt_v, 16);
    chk("D_dones", cnt_d, 1);
    chk("D_q_empty", a_px_q.size() + a_ad_q.size(), 0);
    // reset at 8 mid-READ, replay
    for (int c = 0; c < 32; c++) begin
      rst_n = !(c == 8);
      start_a = c == 0 || c == 11;
      if (c == 0) push_a();
      if (c == 8) clear_a();
      if (c == 11) push_a();
      @(negedge clk);
      if (c == 8) begin
        chk("E_rst_rd", a_rd, 0);
        chk("E_rst_addr", a_addr, 0);
        chk("E_rst_valid", a_valid, 0);
        chk("E_rst_last", a_last, 0);
        chk("E_rst_busy", a_busy, 0);
        chk("E_rst_data0", a_d[0], 0);
        chk("E_rst_data7", a_d[7], 0);
      end
      if (c == 12) chk("E_replay_addr", {a_rd, a_addr}, {1'b1, 4'd0});
      chk("E_valid", a_valid, (c >= 2 && c <= 7) || (c >= 13 && c <= 28));
      chk("E_done", a_done, c == 29);
      next_cycle();
    end
    chk("E_q_empty", a_px_q.size() + a_ad_q.size(), 0);
    // no flush rows, base address 16
    for (int c = 0; c < 17; c++) begin
      start_b = c == 0;
      if (c == 0) push_b();
      @(negedge clk);
      chk("F_rd", b_rd, c >= 1 && c <= 12);
      chk("F_valid", b_valid, c >= 2 && c <= 13);
      chk("F_last", b_last, c == 13);
      chk("F_done", b_done, c == 14);
      chk("F_busy", b_busy, c >= 1 && c <= 13);
      next_cycle();
    end
    chk("F_q_empty", b_px_q.size() + b_ad_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
